// File: rtl/peripheral_bus_responder.sv
// Peripheral bus slave memory responder: serves single and burst transfers from an internal
// array and inserts programmable wait states. It flags illegal transfers and aborted bursts.
module peripheral_bus_responder #(
    parameter int                    ADDR_WIDTH  = 16,
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    MEM_DEPTH   = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 1
) (
    input  logic                  sig_clock,
    input  logic                  sig_reset,
    input  logic                  sig_start,
    input  logic [ADDR_WIDTH-1:0] sig_addr,
    input  logic [1:0]            sig_size,
    input  logic                  sig_read,
    input  logic                  sig_write,
    input  logic                  sig_bip,
    input  logic [DATA_WIDTH-1:0] sig_data_in,
    output logic [DATA_WIDTH-1:0] sig_data_out,
    output logic                  sig_data_oe,
    output logic                  sig_wait,
    output logic                  sig_error,
    output logic                  sig_busy
);

    localparam int XW    = ADDR_WIDTH + 1;
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int WC_W  = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [XW-1:0]   LIMIT   = XW'(BASE_ADDR) + XW'(MEM_DEPTH);
    localparam logic [WC_W-1:0] WC_LOAD = WC_W'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DATA, S_ERR} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    rd_q, rd_d;
    logic [3:0]              beats_q, beats_d;
    logic [WC_W-1:0]         wcnt_q, wcnt_d;
    logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
    logic                    oe_q, oe_d;
    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];
    logic [XW-1:0]           req_lo, req_hi;
    logic                    last_beat, abort, wr_en;

    function automatic logic [IDX_W-1:0] mem_idx(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off = a - BASE_ADDR;
        return off[IDX_W-1:0];
    endfunction

    // Range check is one bit wider than the address so a burst past the top cannot wrap.
    always_comb begin
        req_lo    = XW'(sig_addr);
        req_hi    = XW'(sig_addr) + XW'(4'd1 << sig_size);
        last_beat = (beats_q == 4'd1);
        abort     = !sig_bip && !last_beat;
        wr_en     = (state_q == S_DATA) && !rd_q && !abort;
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rd_d       = rd_q;
        beats_d    = beats_q;
        wcnt_d     = wcnt_q;
        data_out_d = data_out_q;
        oe_d       = 1'b0;
        sig_wait   = 1'b0;
        sig_error  = 1'b0;
        sig_busy   = 1'b1;
        case (state_q)
            S_IDLE: begin
                sig_busy = 1'b0;
                if (sig_start) begin
                    addr_d  = sig_addr;
                    rd_d    = sig_read;
                    beats_d = 4'd1 << sig_size;
                    if (sig_read == sig_write || req_lo < XW'(BASE_ADDR) || req_hi > LIMIT) begin
                        state_d = S_ERR;
                    end else if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        wcnt_d  = WC_LOAD;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_WAIT: begin
                sig_wait = 1'b1;
                if (abort) begin
                    state_d = S_ERR;
                end else if (wcnt_q <= WC_W'(1)) begin
                    state_d = S_DATA;
                end else begin
                    wcnt_d = wcnt_q - WC_W'(1);
                end
            end
            S_DATA: begin
                if (abort) begin
                    state_d = S_ERR;
                end else begin
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                    beats_d = beats_q - 4'd1;
                    if (last_beat) begin
                        state_d = S_IDLE;
                    end else if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        wcnt_d  = WC_LOAD;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_ERR: begin
                sig_error = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Read data is fetched on the edge that enters DATA so it is valid for the whole beat.
        if (state_d == S_DATA && rd_d) begin
            data_out_d = mem[mem_idx(addr_d)];
            oe_d       = 1'b1;
        end
    end

    always_ff @(posedge sig_clock or negedge sig_reset) begin
        if (!sig_reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            rd_q       <= 1'b0;
            beats_q    <= '0;
            wcnt_q     <= '0;
            data_out_q <= '0;
            oe_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rd_q       <= rd_d;
            beats_q    <= beats_d;
            wcnt_q     <= wcnt_d;
            data_out_q <= data_out_d;
            oe_q       <= oe_d;
        end
    end

    always_ff @(posedge sig_clock) begin
        if (wr_en) begin
            mem[mem_idx(addr_q)] <= sig_data_in;
        end
    end

    assign sig_data_out = data_out_q;
    assign sig_data_oe  = oe_q;

endmodule

// File: tb/tb_peripheral_bus_responder.sv
// Randomised bench for peripheral_bus_responder: a default build (one wait state) checked
// against a cycle-timing memory model, plus a zero-wait build for streaming bursts.
module tb_peripheral_bus_responder;

    localparam int W = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [15:0] addr = '0;
    logic [1:0] size = '0;
    logic       rd = 1'b0;
    logic       wr = 1'b0;
    logic       bip = 1'b0;
    logic [7:0] din = '0;
    logic [7:0] dout0, dout1;
    logic       oe0, wait0, err0, busy0;
    logic       oe1, wait1, err1, busy1;

    logic [7:0] mdl  [0:255];
    logic [7:0] wbuf [0:7];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    peripheral_bus_responder #(.WAIT_STATES(W)) dut0 (
        .sig_clock(clk), .sig_reset(rst_n), .sig_start(start), .sig_addr(addr),
        .sig_size(size), .sig_read(rd), .sig_write(wr), .sig_bip(bip),
        .sig_data_in(din), .sig_data_out(dout0), .sig_data_oe(oe0),
        .sig_wait(wait0), .sig_error(err0), .sig_busy(busy0)
    );

    peripheral_bus_responder #(.WAIT_STATES(0)) dut1 (
        .sig_clock(clk), .sig_reset(rst_n), .sig_start(start), .sig_addr(addr),
        .sig_size(size), .sig_read(rd), .sig_write(wr), .sig_bip(bip),
        .sig_data_in(din), .sig_data_out(dout1), .sig_data_oe(oe1),
        .sig_wait(wait1), .sig_error(err1), .sig_busy(busy1)
    );

    // One transfer on the default build; expectations come from the beat timing
    // T+1+W+n*(W+1) and a flat memory array.
    task automatic do_xfer(input string nm, input logic [15:0] a, input logic [1:0] sz,
                           input bit r, input bit w, input int abort_at, input bit spurious);
        int beats, per, k, p;
        bit legal, aborted;
        logic [3:0] exp;
        beats = 1 << sz;
        per   = W + 1;
        legal = (r != w) && (int'(a) + beats <= 256);
        start = 1'b1; addr = a; size = sz; rd = r; wr = w; bip = 1'b1; din = wbuf[0];
        @(negedge clk);
        total++;
        if (busy0 !== 1'b0) begin bad++; $display("FAIL %s start_busy got=%b exp=0", nm, busy0); end
        @(posedge clk); #1;
        start = 1'b0; rd = 1'b0; wr = 1'b0; addr = 16'($urandom);
        aborted = 1'b0;
        if (!legal) begin
            @(negedge clk);
            total++;
            if ({err0, wait0, busy0, oe0} !== 4'b1010) begin
                bad++; $display("FAIL %s err_pulse got=%b exp=1010", nm, {err0, wait0, busy0, oe0});
            end
            @(posedge clk); #1;
        end else begin
            for (int c = 1; c <= beats * per && !aborted; c++) begin
                k = (c - 1) / per;
                p = (c - 1) % per;
                bip = !(abort_at >= 0 && k >= abort_at);
                din = (p == W) ? wbuf[k] : 8'($urandom);
                if (spurious && c == 1) begin
                    start = 1'b1; wr = 1'b1; rd = 1'b0; addr = 16'h0030; size = 2'd0;
                end else begin
                    start = 1'b0; wr = 1'b0;
                end
                exp = {1'b0, (p < W), 1'b1, (r && p == W)};
                @(negedge clk);
                total++;
                if ({err0, wait0, busy0, oe0} !== exp) begin
                    bad++; $display("FAIL %s flags c=%0d got=%b exp=%b", nm, c, {err0, wait0, busy0, oe0}, exp);
                end
                if (r && p == W) begin
                    total++;
                    if (dout0 !== mdl[int'(a) + k]) begin
                        bad++; $display("FAIL %s rdata beat=%0d got=%h exp=%h", nm, k, dout0, mdl[int'(a) + k]);
                    end
                end
                if (!bip) aborted = 1'b1;
                else if (w && p == W) mdl[int'(a) + k] = wbuf[k];
                @(posedge clk); #1;
            end
            start = 1'b0; wr = 1'b0;
            if (aborted) begin
                @(negedge clk);
                total++;
                if ({err0, wait0, busy0, oe0} !== 4'b1010) begin
                    bad++; $display("FAIL %s abort_err got=%b exp=1010", nm, {err0, wait0, busy0, oe0});
                end
                @(posedge clk); #1;
            end
        end
        bip = 1'b0;
        @(negedge clk);
        total++;
        if ({err0, wait0, busy0, oe0} !== 4'b0000) begin
            bad++; $display("FAIL %s back_idle got=%b exp=0000", nm, {err0, wait0, busy0, oe0});
        end
        @(posedge clk); #1;
    endtask

    task automatic rst_pulse();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({dout0, oe0, wait0, err0, busy0, dout1, oe1, wait1, err1, busy1} !== '0) begin
            bad++; $display("FAIL reset_outputs got=%h/%b%b%b%b %h/%b%b%b%b exp=all zero",
                            dout0, oe0, wait0, err0, busy0, dout1, oe1, wait1, err1, busy1);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 32; i++) begin
            for (int j = 0; j < 8; j++) wbuf[j] = 8'($urandom);
            do_xfer("fill", 16'(i * 8), 2'd3, 1'b0, 1'b1, -1, 1'b0);
        end
    endtask

    task automatic test_single();
        wbuf[0] = 8'hA5;
        do_xfer("single_wr", 16'h0010, 2'd0, 1'b0, 1'b1, -1, 1'b0);
        do_xfer("single_rd", 16'h0010, 2'd0, 1'b1, 1'b0, -1, 1'b0);
    endtask

    task automatic test_burst();
        for (int j = 0; j < 4; j++) wbuf[j] = 8'(j + 1);
        do_xfer("burst_wr", 16'h0020, 2'd2, 1'b0, 1'b1, -1, 1'b0);
        do_xfer("burst_rd", 16'h0020, 2'd2, 1'b1, 1'b0, -1, 1'b0);
    endtask

    task automatic test_range();
        wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44;
        do_xfer("range_over", 16'h00FE, 2'd2, 1'b0, 1'b1, -1, 1'b0);
        do_xfer("range_wrap", 16'hFFFC, 2'd2, 1'b1, 1'b0, -1, 1'b0);
        do_xfer("range_high", 16'h0100, 2'd0, 1'b1, 1'b0, -1, 1'b0);
        do_xfer("range_keep", 16'h00FE, 2'd1, 1'b1, 1'b0, -1, 1'b0);
        do_xfer("range_edge", 16'h00F8, 2'd3, 1'b1, 1'b0, -1, 1'b0);
    endtask

    task automatic test_abort();
        for (int j = 0; j < 4; j++) wbuf[j] = 8'($urandom);
        do_xfer("abort_wr", 16'h0040, 2'd2, 1'b0, 1'b1, 2, 1'b0);
        do_xfer("abort_chk", 16'h0040, 2'd2, 1'b1, 1'b0, -1, 1'b0);
    endtask

    task automatic test_reset_mid();
        logic [7:0] nv [0:3];
        for (int j = 0; j < 4; j++) nv[j] = 8'($urandom);
        start = 1'b1; addr = 16'h0060; size = 2'd2; wr = 1'b1; rd = 1'b0; bip = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; wr = 1'b0;
        @(posedge clk); #1;
        din = nv[0];
        @(posedge clk); #1;
        din = nv[1];
        mdl[8'h60] = nv[0];
        total++;
        if (wait0 !== 1'b1) begin bad++; $display("FAIL rstmid_inwait got=%b exp=1", wait0); end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({dout0, oe0, wait0, err0, busy0} !== '0) begin
            bad++; $display("FAIL rstmid_outputs got=%h %b%b%b%b exp=0", dout0, oe0, wait0, err0, busy0);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1; bip = 1'b0;
        do_xfer("rstmid_chk", 16'h0060, 2'd2, 1'b1, 1'b0, -1, 1'b0);
        do_xfer("rstmid_rd10", 16'h0010, 2'd0, 1'b1, 1'b0, -1, 1'b0);
    endtask

    task automatic test_illegal_and_ignored();
        do_xfer("rd_and_wr", 16'h0020, 2'd0, 1'b1, 1'b1, -1, 1'b0);
        do_xfer("no_dir", 16'h0020, 2'd1, 1'b0, 1'b0, -1, 1'b0);
        do_xfer("busy_start", 16'h0010, 2'd0, 1'b1, 1'b0, -1, 1'b1);
        do_xfer("busy_chk30", 16'h0030, 2'd0, 1'b1, 1'b0, -1, 1'b0);
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic [1:0]  sz;
        bit          r, w;
        int          sel, ab;
        for (int n = 0; n < 30; n++) begin
            a  = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(256, 65535)) : 16'($urandom_range(0, 255));
            sz = 2'($urandom_range(0, 3));
            sel = $urandom_range(0, 9);
            if (sel == 0) begin r = 1'b1; w = 1'b1; end
            else if (sel == 1) begin r = 1'b0; w = 1'b0; end
            else begin r = 1'($urandom_range(0, 1)); w = !r; end
            ab = -1;
            if (sz != 2'd0 && $urandom_range(0, 3) == 0) ab = $urandom_range(0, (1 << sz) - 2);
            for (int j = 0; j < 8; j++) wbuf[j] = 8'($urandom);
            do_xfer("random", a, sz, r, w, ab, 1'b0);
        end
    endtask

    task automatic test_w0_stream();
        logic [7:0] d [0:7];
        for (int j = 0; j < 8; j++) d[j] = 8'($urandom);
        rst_pulse();
        start = 1'b1; addr = 16'h0080; size = 2'd3; wr = 1'b1; rd = 1'b0; bip = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; wr = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            din = d[c - 1];
            @(negedge clk);
            total++;
            if ({err1, wait1, busy1, oe1} !== 4'b0010) begin
                bad++; $display("FAIL w0_write c=%0d got=%b exp=0010", c, {err1, wait1, busy1, oe1});
            end
            @(posedge clk); #1;
        end
        bip = 1'b0;
        @(negedge clk);
        total++;
        if (busy1 !== 1'b0) begin bad++; $display("FAIL w0_write_done got=%b exp=0", busy1); end
        @(posedge clk); #1;
        rst_pulse();
        start = 1'b1; addr = 16'h0080; size = 2'd3; rd = 1'b1; bip = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; rd = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            total++;
            if ({err1, wait1, busy1, oe1} !== 4'b0011 || dout1 !== d[c - 1]) begin
                bad++; $display("FAIL w0_stream c=%0d got=%b/%h exp=0011/%h", c, {err1, wait1, busy1, oe1}, dout1, d[c - 1]);
            end
            @(posedge clk); #1;
        end
        bip = 1'b0;
        @(negedge clk);
        total++;
        if ({err1, wait1, busy1, oe1} !== 4'b0000) begin
            bad++; $display("FAIL w0_read_done got=%b exp=0000", {err1, wait1, busy1, oe1});
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_single();
        test_burst();
        test_range();
        test_abort();
        test_reset_mid();
        test_illegal_and_ignored();
        test_random();
        test_w0_stream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
